// File: rtl/uart_tx_if.sv
// Byte handshake between core logic and the UART transmitter.
// The producer drives TX_DATA/TX_VALID; the transmitter answers with TX_READY.
interface uart_tx_if;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;

    modport master (output TX_DATA, output TX_VALID, input TX_READY);
    modport slave  (input TX_DATA, input TX_VALID, output TX_READY);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter (start, 8 data bits LSB first, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and stop.
module uart_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic     CLK50M,
    input  logic     RST_N,
    uart_tx_if.slave bus,
    output logic     TX,
    output logic     BUSY
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    state_t           state_r, state_s;
    logic [BAUD_W-1:0] baud_cnt_r, baud_s;
    logic [2:0]       bit_idx_r, idx_s;
    logic [7:0]       shift_r, shift_s;
    logic             tx_r, tx_s;
`ifdef UART_TX_PARITY_EN
    logic             parity_r, parity_s;
`endif

    logic full_s, empty_s, push_s, pop_s, bit_done_s;
    logic [7:0] head_s;

    assign full_s       = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s      = (count_r == CNT_W'(0));
    assign push_s       = bus.TX_VALID && !full_s;
    assign head_s       = mem_r[rd_ptr_r];
    assign bit_done_s   = (baud_cnt_r == BAUD_W'(CLKS_PER_BIT - 1));
    assign bus.TX_READY = !full_s;
    assign TX           = tx_r;
    assign BUSY         = (state_r != ST_IDLE) || !empty_s;

    // Byte FIFO storage, pointers and occupancy; full refuses a push even on a popping edge.
    always_ff @(posedge CLK50M or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= bus.TX_DATA;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame state register; TX is registered here so the pin never glitches.
    always_ff @(posedge CLK50M or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= BAUD_W'(0);
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_s;
            bit_idx_r  <= idx_s;
            shift_r    <= shift_s;
            tx_r       <= tx_s;
`ifdef UART_TX_PARITY_EN
            parity_r   <= parity_s;
`endif
        end
    end

    // Next-state logic; TX is set to the level of the bit being entered on each transition.
    always_comb begin
        state_s  = state_r;
        baud_s   = baud_cnt_r;
        idx_s    = bit_idx_r;
        shift_s  = shift_r;
        tx_s     = tx_r;
        pop_s    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_s = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                tx_s   = 1'b1;
                baud_s = BAUD_W'(0);
                if (!empty_s) begin
                    pop_s    = 1'b1;
                    shift_s  = head_s;
                    tx_s     = 1'b0;
                    state_s  = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_s = even_parity(head_s);
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    baud_s  = BAUD_W'(0);
                    tx_s    = shift_r[0];
                    idx_s   = 3'd0;
                    state_s = ST_DATA;
                end else begin
                    baud_s = baud_cnt_r + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    baud_s = BAUD_W'(0);
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_s    = parity_r;
                        state_s = ST_PARITY;
`else
                        tx_s    = 1'b1;
                        state_s = ST_STOP;
`endif
                    end else begin
                        shift_s = {1'b0, shift_r[7:1]};
                        tx_s    = shift_r[1];
                        idx_s   = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_cnt_r + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done_s) begin
                    baud_s  = BAUD_W'(0);
                    tx_s    = 1'b1;
                    state_s = ST_STOP;
                end else begin
                    baud_s = baud_cnt_r + BAUD_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_done_s) begin
                    baud_s = BAUD_W'(0);
                    // Chain straight into the next start bit when more data is queued.
                    if (!empty_s) begin
                        pop_s    = 1'b1;
                        shift_s  = head_s;
                        tx_s     = 1'b0;
                        state_s  = ST_START;
`ifdef UART_TX_PARITY_EN
                        parity_s = even_parity(head_s);
`endif
                    end else begin
                        tx_s    = 1'b1;
                        state_s = ST_IDLE;
                    end
                end else begin
                    baud_s = baud_cnt_r + BAUD_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                baud_s  = BAUD_W'(0);
                tx_s    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a fast instance (4 clocks per bit) and a default-rate
// instance (434 clocks per bit); honours UART_TX_PARITY_EN for the expected frame shape.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int SLOW_CPB = 434;

    logic clk;
    logic rst_n_f, rst_n_s;
    logic tx_f, busy_f, tx_s, busy_s;
    int   vectors;
    int   miscompares;

    uart_tx_if if_f ();
    uart_tx_if if_s ();

    uart_tx #(.CLK_FREQ(16), .BAUD(4), .FIFO_DEPTH(4)) dut_fast (
        .CLK50M (clk),
        .RST_N  (rst_n_f),
        .bus    (if_f.slave),
        .TX     (tx_f),
        .BUSY   (busy_f)
    );

    uart_tx dut_slow (
        .CLK50M (clk),
        .RST_N  (rst_n_s),
        .bus    (if_s.slave),
        .TX     (tx_s),
        .BUSY   (busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of frame bit k: start, 8 data bits LSB first, optional even parity, stop.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        else if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        else if (k == 9) return ^b;
`endif
        else return 1'b1;
    endfunction

    // Checks each bit of a fast-instance frame mid-bit, starting at negedge offset off
    // from the start-bit negedge; returns at the negedge one frame after the start.
    task automatic check_frame(input string tag, input logic [7:0] b, input int off);
        int pos;
        pos = off;
        for (int k = 0; k < NB; k++) begin
            if (4 * k + 2 >= pos) begin
                tick(4 * k + 2 - pos);
                pos = 4 * k + 2;
                check($sformatf("%s_bit%0d", tag, k), tx_f, exp_bit(b, k));
            end
        end
        tick(4 * NB - pos);
    endtask

    task automatic reset_fast();
        if_f.TX_VALID = 1'b0;
        rst_n_f = 1'b0;
        tick(2);
        rst_n_f = 1'b1;
        tick(1);
    endtask

    initial begin
        logic bad;
        vectors     = 0;
        miscompares = 0;
        rst_n_f = 1'b0;
        rst_n_s = 1'b0;
        if_f.TX_VALID = 1'b0;
        if_f.TX_DATA  = 8'h00;
        if_s.TX_VALID = 1'b0;
        if_s.TX_DATA  = 8'h00;

        // Reset values
        tick(1);
        check("rst_tx_f", tx_f, 1'b1);
        check("rst_busy_f", busy_f, 1'b0);
        check("rst_ready_f", if_f.TX_READY, 1'b1);
        check("rst_tx_s", tx_s, 1'b1);
        check("rst_busy_s", busy_s, 1'b0);
        rst_n_f = 1'b1;
        rst_n_s = 1'b1;
        tick(1);
        check("post_rst_tx_f", tx_f, 1'b1);
        check("post_rst_busy_f", busy_f, 1'b0);

        // Test 1: default rate, 0x55
        if_s.TX_DATA  = 8'h55;
        if_s.TX_VALID = 1'b1;
        tick(1);
        if_s.TX_VALID = 1'b0;
        tick(1);
        check("t1_start", tx_s, 1'b0);
        for (int k = 0; k < NB; k++) begin
            tick((k == 0) ? SLOW_CPB / 2 : SLOW_CPB);
            check($sformatf("t1_bit%0d", k), tx_s, exp_bit(8'h55, k));
        end
        tick(SLOW_CPB - SLOW_CPB / 2 - 1);
        check("t1_last_cycle_busy", busy_s, 1'b1);
        check("t1_last_cycle_tx", tx_s, 1'b1);
        tick(1);
        check("t1_end_busy", busy_s, 1'b0);
        check("t1_end_tx", tx_s, 1'b1);

        // Test 2: one-cycle push of 0xA3, latency and frame
        reset_fast();
        if_f.TX_DATA  = 8'hA3;
        if_f.TX_VALID = 1'b1;
        tick(1);
        if_f.TX_VALID = 1'b0;
        check("t2_lat_pre", tx_f, 1'b1);
        check("t2_busy", busy_f, 1'b1);
        tick(1);
        check("t2_lat_fall", tx_f, 1'b0);
        check_frame("t2", 8'hA3, 0);
        check("t2_idle_tx", tx_f, 1'b1);
        check("t2_idle_busy", busy_f, 1'b0);

        // Test 4: parity values (plain 8N1 frames without the macro)
        reset_fast();
        if_f.TX_DATA  = 8'h07;
        if_f.TX_VALID = 1'b1;
        tick(1);
        if_f.TX_VALID = 1'b0;
        tick(1);
        check("t4_07_start", tx_f, 1'b0);
        check_frame("t4_07", 8'h07, 0);
        check("t4_07_idle", tx_f, 1'b1);
        check("t4_07_busy", busy_f, 1'b0);
        if_f.TX_DATA  = 8'h03;
        if_f.TX_VALID = 1'b1;
        tick(1);
        if_f.TX_VALID = 1'b0;
        tick(1);
        check("t4_03_start", tx_f, 1'b0);
        check_frame("t4_03", 8'h03, 0);
        check("t4_03_idle", tx_f, 1'b1);

        // Test 3 and 6: continuous push of 0x01..0x06
        reset_fast();
        for (int i = 1; i <= 5; i++) begin
            if_f.TX_DATA  = 8'(i);
            if_f.TX_VALID = 1'b1;
            check($sformatf("t3_ready_pre%0d", i), if_f.TX_READY, 1'b1);
            if (i == 3) check("t3_f1_start", tx_f, 1'b0);
            tick(1);
        end
        if_f.TX_DATA = 8'h06;
        check("t3_full", if_f.TX_READY, 1'b0);
        check_frame("t3_f1", 8'h01, 3);
        check("t6_pop_no_push", if_f.TX_READY, 1'b1);
        check("t3_gap1", tx_f, 1'b0);
        tick(1);
        check("t6_held_accepted", if_f.TX_READY, 1'b0);
        if_f.TX_VALID = 1'b0;
        check_frame("t3_f2", 8'h02, 1);
        for (int b = 3; b <= 6; b++) begin
            check($sformatf("t3_gap%0d", b - 1), tx_f, 1'b0);
            check_frame($sformatf("t3_f%0d", b), 8'(b), 0);
        end
        check("t3_idle_tx", tx_f, 1'b1);
        check("t3_idle_busy", busy_f, 1'b0);

        // Test 5: reset during data bit 3 with 2 bytes queued
        reset_fast();
        if_f.TX_DATA  = 8'h00;
        if_f.TX_VALID = 1'b1;
        tick(1);
        if_f.TX_DATA = 8'h11;
        tick(1);
        if_f.TX_DATA = 8'h22;
        tick(1);
        if_f.TX_VALID = 1'b0;
        tick(16);
        check("t5_pre_tx", tx_f, 1'b0);
        check("t5_pre_busy", busy_f, 1'b1);
        rst_n_f = 1'b0;
        #1;
        check("t5_rst_tx", tx_f, 1'b1);
        check("t5_rst_ready", if_f.TX_READY, 1'b1);
        check("t5_rst_busy", busy_f, 1'b0);
        tick(1);
        rst_n_f = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (tx_f !== 1'b1 || busy_f !== 1'b0) bad = 1'b1;
        end
        check("t5_no_resume", bad, 1'b0);
        check("t5_ready_after", if_f.TX_READY, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Standalone UART transmitter for the 50 MHz fabric. It takes bytes from core logic over a valid/ready handshake and buffers them in a 4-entry FIFO. Each byte is serialised onto TX as an 8N1 frame: start bit, 8 data bits LSB first, and one stop bit. An optional even-parity bit can be compiled in. It drives the board TX pin; the serial receive side is a separate block.

## Interface
- CLK_FREQ, 50000000, input clock frequency in Hz
- BAUD, 115200, line rate in bits/s
- CLKS_PER_BIT (localparam) = CLK_FREQ / BAUD, integer division, truncated (434 at defaults); must be ≥ 2
- FIFO_DEPTH, 4, byte buffer depth; power of two, ≥ 2
- CLK50M  input  1  system clock, all logic on rising edge
- RST_N  input  1  reset, asynchronous assert, active-low
- TX_DATA  input  8  byte to send
- TX_VALID  input  1  TX_DATA is valid this cycle
- TX_READY  output  1  FIFO can accept a byte (= !full)
- TX  output  1  serial line, idle high, registered
- BUSY  output  1  frame in progress or FIFO non-empty

## Operation
- Push: the byte is written at a rising edge where TX_VALID && TX_READY. With TX_VALID high and TX_READY low, nothing is written and the producer must hold the data.
- TX_READY is combinational from the registered FIFO count and reflects full only. A pop in the same cycle does not raise it; full refuses the push even if a pop happens on that edge.
- FIFO read/write pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1. Simultaneous push and pop leave the count unchanged.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: TX=1. If the FIFO is non-empty, pop into an 8-bit shift register, TX←0, go to START.
  - START: hold for CLKS_PER_BIT cycles, then TX←shift[0], bit index←0, go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles, then shift right and increment the 3-bit index. After index 7 completes, go to PARITY (TX←parity) or STOP (TX←1).
  - PARITY: hold CLKS_PER_BIT cycles, then TX←1, go to STOP.
  - STOP: hold CLKS_PER_BIT cycles. If the FIFO is non-empty, pop, TX←0, go to START (no extra idle cycle); otherwise go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 and resets on every bit transition.
- BUSY = (state != IDLE) || (count != 0).

## Timing
- Reset values: TX=1, BUSY=0, TX_READY=1, FIFO empty, state IDLE, counters 0. These take effect immediately on RST_N low.
- Reset mid-frame aborts the frame and discards the FIFO contents. After release, nothing resumes until new pushes arrive.
- Latency: a byte pushed at edge N into an empty FIFO while the FSM is IDLE makes TX fall after edge N+1.
- Every bit lasts exactly CLKS_PER_BIT cycles.
- Frame length is 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- Back-to-back frames: the next start bit immediately follows the last stop-bit cycle.
- Pushing every cycle from empty/IDLE: 5 bytes are accepted at edges 0–4 (the first is popped at edge 1), and TX_READY drops after edge 4. It rises the cycle after the pop at the end of frame 1.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state included. It sends the even-parity bit (XOR of the 8 data bits) between data bit 7 and stop, giving an 11-bit frame.
- Undefined: no PARITY state or logic; 8N1 frame of 10 bits.

## Test plan
- Use CLK_FREQ=16, BAUD=4 (CLKS_PER_BIT=4) for fast tests, except test 1.
1. Defaults, push 0x55 -> TX sampled mid-bit reads 0,1,0,1,0,1,0,1,0,1. Each bit is 434 cycles, frame 4340 cycles; BUSY falls the cycle after the stop bit ends.
2. Push 0xA3 with TX_VALID high one cycle from reset -> TX falls after the next edge; data bits 1,1,0,0,0,1,0,1; stop high; TX returns idle.
3. TX_VALID held high with 0x01..0x06 -> 0x01–0x05 accepted at edges 0–4, TX_READY low from edge 5. 0x06 is accepted on the cycle after frame 1 ends. TX emits six contiguous frames with no idle gap, in order.
4. UART_TX_PARITY_EN defined, push 0x07 -> parity bit 1, frame 44 cycles. Push 0x03 -> parity bit 0.
5. RST_N pulsed low during data bit 3 with 2 bytes queued -> TX=1, TX_READY=1, BUSY=0 immediately. After release TX stays high and no frame is emitted.
6. FIFO full and TX_VALID held while the FSM pops at the end of a stop bit -> that edge has no push; the count drops by 1 and the held byte is accepted the next cycle.
